// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: one single-bit LSR/ASR/LSL/ROR step per clock,
// with start/in_ready and out_valid/out_ready handshakes and flush abort.
module shift_unit_seq #(
  parameter int B_W  = 8,
  parameter int SH_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [B_W-1:0]  A,
  input  logic [SH_W-1:0] B,
  input  logic            flush,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [B_W-1:0]  Y,
  output logic            E
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [B_W-1:0]  y_q, y_d, step_y;
  logic            e_q, e_d, step_e;
  logic [1:0]      op_q, op_d;
  logic [SH_W-1:0] cnt_q, cnt_d;

  always_comb begin
    step_y = y_q;
    step_e = e_q;
    unique case (op_q)
      2'b00: begin
        step_e = y_q[0];
        step_y = {1'b0, y_q[B_W-1:1]};
      end
      2'b01: begin
        step_e = y_q[0];
        step_y = {y_q[B_W-1], y_q[B_W-1:1]};
      end
      2'b10: begin
        step_e = y_q[B_W-1];
        step_y = {y_q[B_W-2:0], 1'b0};
      end
      2'b11: begin
        step_e = y_q[0];
        step_y = {y_q[0], y_q[B_W-1:1]};
      end
      default: ;
    endcase
  end

  // flush outranks both start and out_ready in every state
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    e_d     = e_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          y_d   = A;
          e_d   = 1'b0;
          op_d  = op;
          cnt_d = B;
          state_d = (B == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          y_d   = step_y;
          e_d   = step_e;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == SH_W'(1))
            state_d = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      e_q     <= 1'b0;
      op_q    <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      e_q     <= e_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Y         = y_q;
  assign E         = e_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (B_W=8, SH_W=4):
// hand-computed results, latency, DONE hold, flush and reset aborts.
module tb_shift_unit_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] A;
  logic [3:0] B;
  logic       flush;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Y;
  logic       E;

  int n_chk;
  int n_pass;

  shift_unit_seq #(.B_W(8), .SH_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .A         (A),
    .B         (B),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .E         (E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Accept one op, then wait for out_valid and check latency/result.
  task automatic run_op(input string tag,
                        input logic [1:0] o,
                        input logic [7:0] a,
                        input logic [3:0] b,
                        input logic [7:0] ey,
                        input logic       ee,
                        input int         elat);
    int  lat;
    bit  seen;
    @(negedge clk);
    chk({tag, "_rdy"}, in_ready, 1'b1);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_y"}, Y, ey);
    chk({tag, "_e"}, E, ee);
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, in_ready, 1'b1);
    chk({tag, "_vlow"}, out_valid, 1'b0);
  endtask

  task automatic watch_no_valid(input string tag);
    int hits;
    hits = 0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk(tag, hits, 0);
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = 2'b00;
    A         = 8'h00;
    B         = 4'd0;
    flush     = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_y", Y, 8'h00);
    chk("rst_e", E, 1'b0);
    chk("rst_v", out_valid, 1'b0);
    chk("rst_r", in_ready, 1'b1);
    rst_n = 1'b1;

    run_op("lsr2", 2'b00, 8'hB2, 4'd2, 8'h2C, 1'b1, 2);
    consume("lsr2");
    run_op("asr3", 2'b01, 8'hB2, 4'd3, 8'hF6, 1'b0, 3);
    consume("asr3");
    run_op("lsl2", 2'b10, 8'hB2, 4'd2, 8'hC8, 1'b0, 2);
    consume("lsl2");
    run_op("ror4", 2'b11, 8'hB2, 4'd4, 8'h2B, 1'b0, 4);
    consume("ror4");
    run_op("lsl0", 2'b10, 8'hB2, 4'd0, 8'hB2, 1'b0, 1);
    consume("lsl0");
    run_op("ror0", 2'b11, 8'hB2, 4'd0, 8'hB2, 1'b0, 1);
    consume("ror0");
    run_op("lsr10", 2'b00, 8'hB2, 4'd10, 8'h00, 1'b0, 10);
    consume("lsr10");
    run_op("asr10", 2'b01, 8'hB2, 4'd10, 8'hFF, 1'b1, 10);
    consume("asr10");
    run_op("ror10", 2'b11, 8'hB2, 4'd10, 8'hAC, 1'b1, 10);
    consume("ror10");

    // DONE holds through 5 stalled cycles while start is pushed
    run_op("hold", 2'b00, 8'hB2, 4'd2, 8'h2C, 1'b1, 2);
    start = 1'b1;
    A     = 8'h55;
    B     = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_v", out_valid, 1'b1);
      chk("hold_y", Y, 8'h2C);
      chk("hold_e", E, 1'b1);
    end
    start = 1'b0;
    consume("hold");

    // flush in IDLE blocks a concurrent start
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    A     = 8'hB2;
    B     = 4'd0;
    @(posedge clk);
    #1 start = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("fidle_r", in_ready, 1'b1);
    chk("fidle_v", out_valid, 1'b0);

    // flush in DONE wins over out_ready
    run_op("fdone", 2'b01, 8'hB2, 4'd3, 8'hF6, 1'b0, 3);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("fdone_r", in_ready, 1'b1);
    chk("fdone_y", Y, 8'hF6);

    // flush mid-SHIFT after 3 steps of LSR 12 on B2
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    A     = 8'hB2;
    B     = 4'd12;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fsh_busy", in_ready, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("fsh_r", in_ready, 1'b1);
    chk("fsh_y", Y, 8'h16);
    chk("fsh_e", E, 1'b0);
    watch_no_valid("fsh_nov");

    // reset mid-SHIFT zeroes the result
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    A     = 8'hB2;
    B     = 4'd12;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rsh_r", in_ready, 1'b1);
    chk("rsh_y", Y, 8'h00);
    chk("rsh_e", E, 1'b0);
    watch_no_valid("rsh_nov");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
